// File: rtl/ltz_cdcs.sv
// CDC source-side stabiliser: paces multi-bit updates toward an asynchronous receiver
// so that each dout value stays stable for at least HOLD clocks, with a one-deep pending slot.
module ltz_cdcs #(
    parameter int unsigned WIDTH   = 1,
    parameter logic [WIDTH-1:0] INITVAL = {WIDTH{1'b0}},
    parameter int unsigned HOLD    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_chg,
    output logic             busy
);

    // Guarded width keeps the counter legal long enough for the HOLD check to report.
    localparam int unsigned CW = (HOLD < 2) ? 1 : $clog2(HOLD);

    if (HOLD < 2) begin : g_bad_hold
        $error("ltz_cdcs: HOLD must be at least 2");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             pend_vld;
    logic [WIDTH-1:0] pend;

    logic free;
    logic xfer;

    assign din_rdy = !pend_vld;
    assign busy    = (state == ST_HOLD) || pend_vld;
    assign free    = (state == ST_IDLE) || (cnt == '0);
    assign xfer    = din_vld && din_rdy;

    // Pending slot has priority at expiry; otherwise a fresh transfer loads directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pend_vld <= 1'b0;
            pend     <= INITVAL;
            dout     <= INITVAL;
            dout_chg <= 1'b0;
        end else begin
            dout_chg <= 1'b0;
            if (free) begin
                if (pend_vld) begin
                    pend_vld <= 1'b0;
                    if (pend != dout) begin
                        dout     <= pend;
                        cnt      <= CW'(HOLD - 1);
                        state    <= ST_HOLD;
                        dout_chg <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end else if (xfer && (din != dout)) begin
                    dout     <= din;
                    cnt      <= CW'(HOLD - 1);
                    state    <= ST_HOLD;
                    dout_chg <= 1'b1;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                cnt <= cnt - CW'(1);
                if (xfer) begin
                    pend     <= din;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ltz_cdcs.sv
// Directed bench for ltz_cdcs: HOLD=4 main instance plus a HOLD=2 instance for minimum spacing.
module tb_ltz_cdcs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din, din2;
    logic       din_vld, din_vld2;
    logic       din_rdy, din_rdy2;
    logic [7:0] dout, dout2;
    logic       dout_chg, dout_chg2;
    logic       busy, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    int         chg_cyc[$];
    logic [7:0] chg_val[$];

    always #5 clk = ~clk;

    ltz_cdcs #(.WIDTH(8), .INITVAL(8'h00), .HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .dout(dout), .dout_chg(dout_chg), .busy(busy)
    );

    ltz_cdcs #(.WIDTH(8), .INITVAL(8'h00), .HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .din_vld(din_vld2), .din_rdy(din_rdy2),
        .dout(dout2), .dout_chg(dout_chg2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = 8'h00; din_vld = 1'b0; din2 = 8'h00; din_vld2 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h want 00", dout); end
        n_cmp++; if (din_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", din_rdy); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (dout_chg !== 1'b0) begin n_bad++; $display("FAIL reset_chg got %b want 0", dout_chg); end
    endtask

    task automatic test_single();
        din = 8'h5A; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL single_dout got %h want 5a", dout); end
        n_cmp++; if (dout_chg !== 1'b1) begin n_bad++; $display("FAIL single_chg got %b want 1", dout_chg); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy0 got %b want 1", busy); end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_cmp++; if (busy !== 1'b1 || dout_chg !== 1'b0)
                begin n_bad++; $display("FAIL single_hold%0d busy/chg got %b%b want 10", i, busy, dout_chg); end
        end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        int         idx;
        logic       x;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        idx = 0;
        chg_cyc.delete(); chg_val.delete();
        din = vals[0]; din_vld = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            x = din_vld && din_rdy;
            tick();
            if (x) idx++;
            if (idx < 3) din = vals[idx]; else din_vld = 1'b0;
            if (dout_chg === 1'b1) begin chg_cyc.push_back(c); chg_val.push_back(dout); end
            if (c == 3) begin
                n_cmp++; if (din_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_rdy_full got %b want 0", din_rdy); end
            end
            if (c == 6) begin
                n_cmp++; if (din_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_rdy_full2 got %b want 0", din_rdy); end
            end
        end
        n_cmp++; if (chg_cyc.size() != 3) begin n_bad++; $display("FAIL b2b_pulses got %0d want 3", chg_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= chg_cyc.size()) begin
                n_bad++; $display("FAIL b2b_change%0d missing want cycle %0d", i, 1 + 4*i);
            end else if (chg_cyc[i] != 1 + 4*i || chg_val[i] !== vals[i]) begin
                n_bad++; $display("FAIL b2b_change%0d got c%0d/%h want c%0d/%h",
                                  i, chg_cyc[i], chg_val[i], 1 + 4*i, vals[i]);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_same_value();
        int pulses;
        din = 8'h33; din_vld = 1'b1;
        n_cmp++; if (din_rdy !== 1'b1) begin n_bad++; $display("FAIL same_rdy got %b want 1", din_rdy); end
        tick();
        din_vld = 1'b0;
        n_cmp++; if (dout_chg !== 1'b0 || busy !== 1'b0 || dout !== 8'h33)
            begin n_bad++; $display("FAIL same_drop chg/busy/dout got %b/%b/%h want 0/0/33", dout_chg, busy, dout); end
        din = 8'h5A; din_vld = 1'b1;
        tick();
        din = 8'h5A;
        tick();
        din_vld = 1'b0;
        n_cmp++; if (din_rdy !== 1'b0 || busy !== 1'b1)
            begin n_bad++; $display("FAIL same_queued rdy/busy got %b/%b want 0/1", din_rdy, busy); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dout_chg === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL same_expiry_pulses got %0d want 0", pulses); end
        n_cmp++; if (busy !== 1'b0 || din_rdy !== 1'b1 || dout !== 8'h5A)
            begin n_bad++; $display("FAIL same_cleared busy/rdy/dout got %b/%b/%h want 0/1/5a", busy, din_rdy, dout); end
    endtask

    task automatic test_expiry();
        din = 8'h66; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b1 || din_rdy !== 1'b1)
            begin n_bad++; $display("FAIL expiry_pre busy/rdy got %b/%b want 1/1", busy, din_rdy); end
        din = 8'h77; din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        n_cmp++; if (dout !== 8'h77 || dout_chg !== 1'b1 || busy !== 1'b1)
            begin n_bad++; $display("FAIL expiry_load dout/chg/busy got %h/%b/%b want 77/1/1", dout, dout_chg, busy); end
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL expiry_hold busy got %b want 1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL expiry_end busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int bad_seen;
        din = 8'h12; din_vld = 1'b1;
        tick();
        din = 8'h34;
        tick();
        din_vld = 1'b0;
        n_cmp++; if (din_rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid_full rdy got %b want 0", din_rdy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (dout !== 8'h00 || din_rdy !== 1'b1 || busy !== 1'b0 || dout_chg !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_async dout/rdy/busy/chg got %h/%b/%b/%b want 00/1/0/0",
                                    dout, din_rdy, busy, dout_chg); end
        tick();
        rst_n = 1'b1;
        bad_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dout_chg === 1'b1 || dout !== 8'h00) bad_seen++;
        end
        n_cmp++; if (bad_seen != 0) begin n_bad++; $display("FAIL rstmid_ghost got %0d bad cycles want 0", bad_seen); end
    endtask

    task automatic test_hold2();
        logic [7:0] vals [4];
        int         idx;
        logic       x;
        vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3; vals[3] = 8'hA4;
        idx = 0;
        chg_cyc.delete(); chg_val.delete();
        din2 = vals[0]; din_vld2 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            x = din_vld2 && din_rdy2;
            tick();
            if (x) idx++;
            if (idx < 4) din2 = vals[idx]; else din_vld2 = 1'b0;
            if (dout_chg2 === 1'b1) begin chg_cyc.push_back(c); chg_val.push_back(dout2); end
        end
        n_cmp++; if (chg_cyc.size() != 4) begin n_bad++; $display("FAIL h2_pulses got %0d want 4", chg_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= chg_cyc.size()) begin
                n_bad++; $display("FAIL h2_change%0d missing want cycle %0d", i, 1 + 2*i);
            end else if (chg_cyc[i] != 1 + 2*i || chg_val[i] !== vals[i]) begin
                n_bad++; $display("FAIL h2_change%0d got c%0d/%h want c%0d/%h",
                                  i, chg_cyc[i], chg_val[i], 1 + 2*i, vals[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_same_value();
        test_expiry();
        test_reset_mid();
        test_hold2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
